// File: rtl/fx_pkg.sv
// Shared definitions for the frame effect controller: FSM state encoding,
// effect bit positions and mask width.
package fx_pkg;

    localparam int FX_W    = 4;
    localparam int FX_GRAY = 0;
    localparam int FX_INV  = 1;
    localparam int FX_EDGE = 2;
    localparam int FX_MIRR = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        APPLY  = 2'd2,
        SETTLE = 2'd3
    } fx_state_e;

    typedef logic [FX_W-1:0] fx_mask_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer with optional stability filter and a registered
// one-cycle rising-edge pulse.
module sync_debounce
    import fx_pkg::*;
#(
    parameter bit DEBOUNCE   = 1'b0,
    parameter int DEB_CYCLES = 1,
    parameter bit HOLD_OFF   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [1:0] sync_reg;
    logic [1:0] fill_reg;
    logic       level;
    logic       level_prev_reg;
    logic       seen_low_reg;
    logic       rise_reg;

    generate
        if (DEBOUNCE) begin : g_deb
            localparam int CW = $clog2(DEB_CYCLES + 1);
            logic [CW-1:0] cnt_reg;
            logic          stable_reg;

            // The filtered level only follows the input after DEB_CYCLES
            // consecutive cycles of disagreement.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync_reg[1] == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                    stable_reg <= sync_reg[1];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end

            assign level = stable_reg;
        end else begin : g_nodeb
            assign level = sync_reg[1];
        end
    endgenerate

    // With HOLD_OFF, an input already high out of reset must be seen low
    // (after the synchronizer has filled) before any edge is reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= '0;
            fill_reg       <= '0;
            level_prev_reg <= 1'b0;
            seen_low_reg   <= 1'b0;
            rise_reg       <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[0], din};
            fill_reg       <= {fill_reg[0], 1'b1};
            level_prev_reg <= level;
            if (fill_reg[1] && !sync_reg[1] && !level) begin
                seen_low_reg <= 1'b1;
            end
            rise_reg <= level & ~level_prev_reg & (seen_low_reg | ~HOLD_OFF);
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/frame_fx_ctrl.sv
// Frame-synchronous effect-mask controller. Define FX_DEBOUNCE_EN to enable
// the DEB_CYCLES stability filter on btn_req.
module frame_fx_ctrl
    import fx_pkg::*;
#(
    parameter int DEB_CYCLES    = 50000,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vsync,
    input  logic            btn_req,
    input  logic [FX_W-1:0] sw_mode,
    output logic [FX_W-1:0] fx_en,
    output logic            frame_en,
    output logic            pending,
    output logic [15:0]     frame_cnt
);

`ifdef FX_DEBOUNCE_EN
    localparam bit BTN_DEBOUNCE = 1'b1;
`else
    localparam bit BTN_DEBOUNCE = 1'b0;
`endif

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ARMED  = ARMED;
    localparam logic [1:0] S_APPLY  = APPLY;
    localparam logic [1:0] S_SETTLE = SETTLE;

    localparam int SW = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);

    logic [1:0]  state_reg;
    fx_mask_t    fx_reg;
    fx_mask_t    pend_mask_reg;
    logic        queued_reg;
    logic [SW-1:0] settle_cnt_reg;
    logic [15:0] frame_cnt_reg;
    logic        press;
    logic        frame_pulse;

    sync_debounce #(
        .DEBOUNCE   (1'b0),
        .DEB_CYCLES (1),
        .HOLD_OFF   (1'b0)
    ) vsync_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (vsync),
        .rise (frame_pulse)
    );

    sync_debounce #(
        .DEBOUNCE   (BTN_DEBOUNCE),
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_OFF   (1'b1)
    ) btn_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_req),
        .rise (press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            fx_reg         <= '0;
            pend_mask_reg  <= '0;
            queued_reg     <= 1'b0;
            settle_cnt_reg <= '0;
            frame_cnt_reg  <= '0;
        end else begin
            if (frame_pulse) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (press) begin
                        pend_mask_reg <= sw_mode;
                        state_reg     <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    // A press coinciding with the frame start wins: the new
                    // mask waits for the following frame.
                    if (press) begin
                        pend_mask_reg <= sw_mode;
                    end else if (frame_pulse) begin
                        state_reg <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    fx_reg         <= pend_mask_reg;
                    settle_cnt_reg <= SW'(SETTLE_FRAMES);
                    queued_reg     <= press;
                    if (press) begin
                        pend_mask_reg <= sw_mode;
                    end
                    state_reg <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (press) begin
                        pend_mask_reg <= sw_mode;
                        queued_reg    <= 1'b1;
                    end
                    if (settle_cnt_reg == '0) begin
                        state_reg  <= (queued_reg | press) ? S_ARMED : S_IDLE;
                        queued_reg <= 1'b0;
                    end else if (frame_pulse) begin
                        settle_cnt_reg <= settle_cnt_reg - SW'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < FX_W; gi++) begin : g_fx
            assign fx_en[gi] = fx_reg[gi];
        end
    endgenerate

    assign frame_en  = frame_pulse;
    assign frame_cnt = frame_cnt_reg;
    assign pending   = (state_reg == S_ARMED) || ((state_reg == S_SETTLE) && queued_reg);

endmodule

// File: tb/tb_frame_fx_ctrl.sv
// Directed bench for frame_fx_ctrl (DEB_CYCLES=8, SETTLE_FRAMES=2); the
// glitch-filter sequence runs only when FX_DEBOUNCE_EN is defined.
module tb_frame_fx_ctrl;
    import fx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        btn_req = 1'b0;
    logic [3:0]  sw_mode = 4'b0000;
    logic [3:0]  fx_en;
    logic        frame_en;
    logic        pending;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    frame_fx_ctrl #(
        .DEB_CYCLES    (8),
        .SETTLE_FRAMES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .btn_req   (btn_req),
        .sw_mode   (sw_mode),
        .fx_en     (fx_en),
        .frame_en  (frame_en),
        .pending   (pending),
        .frame_cnt (frame_cnt)
    );

`ifdef FX_DEBOUNCE_EN
    localparam int HOLD      = 12;
    localparam int PRESS_LAT = 8;
`else
    localparam int HOLD      = 4;
    localparam int PRESS_LAT = 0;
`endif

    typedef struct {
        logic [3:0] mask;
        logic       exp_pend_press;
        logic [3:0] exp_fx;
        logic       exp_pend_after;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_frames = 0;
    logic [3:0] fx_k4;
    logic [3:0] fx_k5;
    logic [3:0] prev_fx;
    vec_t       vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic btn_level);
        @(negedge clk);
        rst = 1'b1;
        vsync = 1'b0;
        btn_req = btn_level;
        tick(3);
        rst = 1'b0;
        exp_frames = 0;
    endtask

    task automatic press(input logic [3:0] m);
        sw_mode = m;
        btn_req = 1'b1;
        tick(HOLD);
        btn_req = 1'b0;
        tick(HOLD);
        sw_mode = ~m;
    endtask

    // vsync high for three cycles; frame_en must appear only after the third edge.
    task automatic frame(input string tag);
        logic [3:0] fe;
        vsync = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            fe[k] = frame_en;
            if (k == 2) vsync = 1'b0;
        end
        fx_k4 = fx_en;
        @(negedge clk);
        fx_k5 = fx_en;
        tick(3);
        exp_frames++;
        check({tag, "_frame_en_shape"}, 32'(fe), 32'(4'b0100));
    endtask

    initial begin
        vecs[0] = '{4'(1 << FX_MIRR), 1'b1, 4'(1 << FX_MIRR), 1'b0};
        vecs[1] = '{4'((1 << FX_INV) | (1 << FX_EDGE)), 1'b1, 4'b0110, 1'b0};
        vecs[2] = '{4'b1111, 1'b1, 4'b1111, 1'b0};
        vecs[3] = '{4'b1111, 1'b1, 4'b1111, 1'b0};
        vecs[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        vecs[5] = '{4'b1010, 1'b1, 4'b1010, 1'b0};

        do_reset(1'b0);
        check("rst_fx_en", 32'(fx_en), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_frame_en", 32'(frame_en), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        tick(5);

        // Basic apply with exact fx_en timing.
        press(4'(1 << FX_GRAY));
        check("b_pend_press", 32'(pending), 1);
        check("b_fx_before", 32'(fx_en), 0);
        frame("b");
        check("b_fx_apply_cycle", 32'(fx_k4), 0);
        check("b_fx_after_apply", 32'(fx_k5), 32'(4'b0001));
        check("b_pend_after", 32'(pending), 0);
        frame("b_s1");
        frame("b_s2");
        prev_fx = 4'b0001;

        for (int i = 0; i < 6; i++) begin
            press(vecs[i].mask);
            check($sformatf("v%0d_pend_press", i), 32'(pending), 32'(vecs[i].exp_pend_press));
            check($sformatf("v%0d_fx_hold", i), 32'(fx_en), 32'(prev_fx));
            frame("v");
            check($sformatf("v%0d_fx", i), 32'(fx_en), 32'(vecs[i].exp_fx));
            check($sformatf("v%0d_pend_after", i), 32'(pending), 32'(vecs[i].exp_pend_after));
            frame("v_s1");
            frame("v_s2");
            check($sformatf("v%0d_frame_cnt", i), 32'(frame_cnt), 32'(exp_frames));
            prev_fx = vecs[i].exp_fx;
        end

        // Second press before the frame overrides the first.
        press(4'b0010);
        press(4'b0100);
        check("ovr_pend", 32'(pending), 1);
        check("ovr_fx_hold", 32'(fx_en), 32'(4'b1010));
        frame("ovr");
        check("ovr_fx", 32'(fx_en), 32'(4'b0100));
        frame("ovr_s1");
        frame("ovr_s2");

        // Press landing on the same cycle as frame_en while ARMED.
        press(4'b1000);
        sw_mode = 4'b0011;
        btn_req = 1'b1;
        tick(PRESS_LAT);
        frame("coinc");
        btn_req = 1'b0;
        tick(HOLD);
        sw_mode = 4'b1100;
        check("coinc_fx_hold", 32'(fx_en), 32'(4'b0100));
        check("coinc_pend", 32'(pending), 1);
        frame("coinc2");
        check("coinc_fx", 32'(fx_en), 32'(4'b0011));

        // Press during SETTLE waits out both settle frames.
        press(4'b0101);
        check("st_pend", 32'(pending), 1);
        check("st_fx0", 32'(fx_en), 32'(4'b0011));
        frame("st1");
        check("st_fx1", 32'(fx_en), 32'(4'b0011));
        check("st_pend1", 32'(pending), 1);
        frame("st2");
        check("st_fx2", 32'(fx_en), 32'(4'b0011));
        check("st_pend2", 32'(pending), 1);
        frame("st3");
        check("st_fx3", 32'(fx_en), 32'(4'b0101));
        check("st_pend3", 32'(pending), 0);
        frame("st_s1");
        frame("st_s2");
        frame("idle");
        check("idle_fx", 32'(fx_en), 32'(4'b0101));
        check("idle_pend", 32'(pending), 0);

        // Button held through reset must not count as a press.
        do_reset(1'b1);
        check("hold_rst_fx", 32'(fx_en), 0);
        tick(20);
        check("hold_no_press", 32'(pending), 0);
        btn_req = 1'b0;
        tick(HOLD);
        press(4'b0111);
        check("hold_rearm", 32'(pending), 1);

        // Reset while ARMED discards the mask.
        do_reset(1'b0);
        check("rarm_fx", 32'(fx_en), 0);
        check("rarm_pend", 32'(pending), 0);
        tick(5);
        frame("rarm");
        check("rarm_fx_frame", 32'(fx_en), 0);
        check("rarm_pend_frame", 32'(pending), 0);

        // Reset while SETTLE with a queued press.
        press(4'b1001);
        frame("rset");
        check("rset_fx", 32'(fx_en), 32'(4'b1001));
        press(4'b0110);
        check("rset_pend", 32'(pending), 1);
        do_reset(1'b0);
        check("rset_fx_rst", 32'(fx_en), 0);
        check("rset_pend_rst", 32'(pending), 0);
        tick(5);
        frame("rset1");
        frame("rset2");
        frame("rset3");
        check("rset_fx_late", 32'(fx_en), 0);

`ifdef FX_DEBOUNCE_EN
        do_reset(1'b0);
        tick(10);
        sw_mode = 4'b1100;
        btn_req = 1'b1;
        tick(5);
        btn_req = 1'b0;
        tick(20);
        check("deb_glitch", 32'(pending), 0);
        btn_req = 1'b1;
        tick(9);
        btn_req = 1'b0;
        tick(20);
        check("deb_held", 32'(pending), 1);
`endif

        // Frame counter wrap.
        do_reset(1'b0);
        tick(3);
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            vsync = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
        end
        tick(5);
        check("cnt_ffff", 32'(frame_cnt), 32'(16'hFFFF));
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        tick(5);
        check("cnt_wrap", 32'(frame_cnt), 0);
        check("cnt_fx", 32'(fx_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
